// File: rtl/ctrl_ramdrv_ringwr_if.sv
// Ring-buffer writer bus: init/bounds, sample stream in,
// registered RAM write port and head/status out.
interface ctrl_ramdrv_ringwr_if #(
  parameter int DATA_ADDRESS_WIDTH = 12,
  parameter int DATA_OFFSET_WIDTH  = 10,
  parameter int DATA_WIDTH         = 16
);
  logic                          init;
  logic [DATA_ADDRESS_WIDTH-1:0] data_uptr;
  logic [DATA_ADDRESS_WIDTH-1:0] data_lptr;
  logic                          lock;
  logic                          s_valid;
  logic [DATA_WIDTH-1:0]         s_data;
  logic                          s_ready;
  logic                          ram_we;
  logic [DATA_ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]         ram_wdata;
  logic [DATA_OFFSET_WIDTH-1:0]  head_offset;
  logic                          new_sample;
  logic                          busy;

  modport master (
    output init, data_uptr, data_lptr,
    output lock, s_valid, s_data,
    input  s_ready, ram_we, ram_addr,
    input  ram_wdata, head_offset,
    input  new_sample, busy
  );

  modport slave (
    input  init, data_uptr, data_lptr,
    input  lock, s_valid, s_data,
    output s_ready, ram_we, ram_addr,
    output ram_wdata, head_offset,
    output new_sample, busy
  );
endinterface

// File: rtl/ctrl_ramdrv_ringwr.sv
// Ring-buffer RAM writer: zero-fills [uptr..lptr] on init,
// then writes each accepted sample at the next ring slot.
module ctrl_ramdrv_ringwr #(
  parameter int DATA_ADDRESS_WIDTH = 12,
  parameter int DATA_OFFSET_WIDTH  = 10,
  parameter int DATA_WIDTH         = 16
) (
  input logic                 clk,
  input logic                 clr,
  ctrl_ramdrv_ringwr_if.slave bus
);
  localparam int AW = DATA_ADDRESS_WIDTH;
  localparam int OW = DATA_OFFSET_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_uptr;
  logic [AW-1:0] r_lptr;
  logic [AW-1:0] r_fill;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [OW-1:0] r_head;
  logic          r_we;
  logic          r_new;
  logic          r_busy;

  logic          w_ready;
  logic          w_accept;
  logic [AW-1:0] w_cur;
  logic [OW-1:0] w_next;
  logic [AW-1:0] w_naddr;

  // Accept only in RUN, unlocked, and not while init/clr override.
  assign w_ready  = (r_state == S_RUN) && !bus.lock
                    && !bus.init && !clr;
  assign w_accept = w_ready && bus.s_valid;
  assign w_cur    = r_uptr + AW'(r_head);
  assign w_next   = (w_cur == r_lptr) ? '0
                    : r_head + OW'(1);
  assign w_naddr  = r_uptr + AW'(w_next);

  // Single FSM: zero-fill sweep, then ring writes of samples.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_uptr  <= '0;
      r_lptr  <= '0;
      r_fill  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_head  <= '0;
      r_we    <= 1'b0;
      r_new   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (bus.init) begin
      r_state <= S_FILL;
      r_uptr  <= bus.data_uptr;
      r_lptr  <= bus.data_lptr;
      r_fill  <= bus.data_uptr;
      r_head  <= '0;
      r_we    <= 1'b0;
      r_new   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          r_we    <= 1'b1;
          r_new   <= 1'b0;
          r_busy  <= 1'b1;
          r_addr  <= r_fill;
          r_wdata <= '0;
          r_fill  <= r_fill + AW'(1);
          if (r_fill == r_lptr)
            r_state <= S_RUN;
        end
        S_RUN: begin
          r_we   <= w_accept;
          r_new  <= w_accept;
          r_busy <= 1'b0;
          if (w_accept) begin
            r_head  <= w_next;
            r_addr  <= w_naddr;
            r_wdata <= bus.s_data;
          end
        end
        default: begin
          r_we   <= 1'b0;
          r_new  <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBUG
  logic [AW:0] w_len;
  assign w_len = {1'b0, bus.data_lptr}
               - {1'b0, bus.data_uptr} + 1'b1;

  // Trap buffer bounds that cannot be represented.
  always_ff @(posedge clk) begin
    if (!clr && bus.init &&
        ((bus.data_lptr < bus.data_uptr) ||
         (w_len > (AW+1)'(2**OW)))) begin
      $display("ERROR: illegal ring bounds");
      $finish(2);
    end
  end
`endif

  assign bus.s_ready     = w_ready;
  assign bus.ram_we      = r_we;
  assign bus.ram_addr    = r_addr;
  assign bus.ram_wdata   = r_wdata;
  assign bus.head_offset = r_head;
  assign bus.new_sample  = r_new;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_ctrl_ramdrv_ringwr.sv
// Bench for ctrl_ramdrv_ringwr: directed ring scenarios
// plus random traffic against a queue-based model.
module tb_ctrl_ramdrv_ringwr;
  localparam int AW = 12;
  localparam int OW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  ctrl_ramdrv_ringwr_if #(
    .DATA_ADDRESS_WIDTH(AW),
    .DATA_OFFSET_WIDTH (OW),
    .DATA_WIDTH        (DW)
  ) bus ();

  ctrl_ramdrv_ringwr #(
    .DATA_ADDRESS_WIDTH(AW),
    .DATA_OFFSET_WIDTH (OW),
    .DATA_WIDTH        (DW)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: buffer bounds, newest-sample offset,
  // outstanding zero-fill addresses, running flag.
  bit m_run = 0;
  int m_u = 0;
  int m_l = 0;
  int m_head = 0;
  int fill_q[$];

  // Observed RAM writes since the last clear of the log.
  int log_a[$];
  int log_d[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    bit e_we, e_new, e_busy, e_ready, was_clr;
    int e_addr, e_data;
    #1;
    e_ready = !clr && !bus.init && m_run && !bus.lock;
    chk("s_ready", 32'(bus.s_ready), 32'(e_ready));
    e_we = 0; e_new = 0; e_busy = 0;
    e_addr = 0; e_data = 0;
    was_clr = clr;
    if (clr) begin
      m_run = 0; m_head = 0; m_u = 0; m_l = 0;
      fill_q.delete();
    end else if (bus.init) begin
      m_run = 0; m_head = 0;
      m_u = int'(bus.data_uptr);
      m_l = int'(bus.data_lptr);
      fill_q.delete();
      for (int a = m_u; a <= m_l; a++) fill_q.push_back(a);
    end else if (fill_q.size() > 0) begin
      e_addr = fill_q.pop_front();
      e_we = 1; e_busy = 1;
      if (fill_q.size() == 0) m_run = 1;
    end else if (e_ready && bus.s_valid) begin
      m_head = (m_u + m_head == m_l) ? 0 : m_head + 1;
      e_we = 1; e_new = 1;
      e_addr = (m_u + m_head) % (1 << AW);
      e_data = int'(bus.s_data);
    end
    @(posedge clk);
    #1;
    chk("ram_we", 32'(bus.ram_we), 32'(e_we));
    chk("new_sample", 32'(bus.new_sample), 32'(e_new));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("head_offset", 32'(bus.head_offset), m_head);
    if (e_we || was_clr) begin
      chk("ram_addr", 32'(bus.ram_addr), e_addr);
      chk("ram_wdata", 32'(bus.ram_wdata), e_data);
    end
    if (bus.ram_we === 1'b1) begin
      log_a.push_back(int'(bus.ram_addr));
      log_d.push_back(int'(bus.ram_wdata));
    end
  endtask

  task automatic set_init(input int u, input int l);
    bus.init = 1'b1;
    bus.data_uptr = AW'(u);
    bus.data_lptr = AW'(l);
  endtask

  int ea[5] = '{'h101, 'h102, 'h103, 'h100, 'h101};

  initial begin
    int r, len, u;
    clr = 1'b1;
    bus.init = 1'b0;
    bus.data_uptr = '0;
    bus.data_lptr = '0;
    bus.lock = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = 16'h1234;

    // Reset held two cycles with a sample offered.
    step();
    step();
    chk("rst_addr", 32'(bus.ram_addr), 0);
    clr = 1'b0;
    bus.s_valid = 1'b0;
    step();

    // Zero-fill of 0x100..0x103.
    log_a.delete(); log_d.delete();
    set_init('h100, 'h103);
    step();
    bus.init = 1'b0;
    repeat (4) step();
    chk("fill_n", log_a.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < log_a.size()) begin
        chk("fill_a", log_a[i], 'h100 + i);
        chk("fill_d", log_d[i], 0);
      end

    // Back-to-back stream wrapping the ring.
    log_a.delete(); log_d.delete();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_data = DW'('h0A + i);
      step();
    end
    bus.s_valid = 1'b0;
    chk("strm_n", log_a.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < log_a.size()) begin
        chk("strm_a", log_a[i], ea[i]);
        chk("strm_d", log_d[i], 'h0A + i);
      end
    chk("strm_head", 32'(bus.head_offset), 1);

    // Lock blocks acceptance; release writes next edge.
    log_a.delete(); log_d.delete();
    bus.lock = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 16'h000F;
    repeat (3) step();
    chk("lock_n", log_a.size(), 0);
    bus.lock = 1'b0;
    step();
    bus.s_valid = 1'b0;
    chk("unlk_n", log_a.size(), 1);
    if (log_a.size() > 0) chk("unlk_a", log_a[0], 'h102);
    chk("unlk_head", 32'(bus.head_offset), 2);

    // Init mid-run with a pending sample.
    log_a.delete(); log_d.delete();
    bus.s_valid = 1'b1;
    bus.s_data = 16'h0077;
    set_init('h100, 'h103);
    step();
    bus.init = 1'b0;
    repeat (4) step();
    bus.s_valid = 1'b0;
    step();
    chk("reinit_n", log_a.size(), 4);
    for (int i = 0; i < log_a.size(); i++)
      chk("reinit_d", log_d[i], 0);
    chk("reinit_head", 32'(bus.head_offset), 0);

    // clr aborts an ongoing fill.
    log_a.delete(); log_d.delete();
    set_init('h100, 'h103);
    step();
    bus.init = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (3) step();
    chk("abort_n", log_a.size(), 1);
    chk("abort_busy", 32'(bus.busy), 0);

    // clr and init together: clr wins.
    clr = 1'b1;
    set_init('h200, 'h201);
    step();
    clr = 1'b0;
    bus.init = 1'b0;
    step();
    chk("clrinit_busy", 32'(bus.busy), 0);

    // Length-1 ring.
    log_a.delete(); log_d.delete();
    set_init('h055, 'h055);
    step();
    bus.init = 1'b0;
    step();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_data = DW'('hA0 + i);
      step();
    end
    bus.s_valid = 1'b0;
    chk("len1_n", log_a.size(), 4);
    for (int i = 0; i < log_a.size(); i++)
      chk("len1_a", log_a[i], 'h055);
    chk("len1_head", 32'(bus.head_offset), 0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      clr = (r < 2);
      bus.init = 1'b0;
      if (r < 1 || (r >= 2 && r < 7)) begin
        len = $urandom_range(1, 8);
        u = $urandom_range(0, (1 << AW) - len);
        set_init(u, u + len - 1);
      end
      bus.lock = ($urandom_range(0, 3) == 0);
      bus.s_valid = $urandom_range(0, 1) == 1;
      bus.s_data = DW'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ctrl_ramdrv_ringwr.md
CTRL_RAMDRV_RINGWR -- requirements
Module: ctrl_ramdrv_ringwr

Interface
REQ-001 SHALL have parameter DATA_ADDRESS_WIDTH, default 12, RAM sample address width.
REQ-002 SHALL have parameter DATA_OFFSET_WIDTH, default 10, head offset width; buffer length SHALL be at most 2^DATA_OFFSET_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port clr, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port init, input, 1, latches buffer bounds and starts zero-fill.
REQ-007 SHALL have port data_uptr, input, DATA_ADDRESS_WIDTH, lowest buffer address (sampled on init).
REQ-008 SHALL have port data_lptr, input, DATA_ADDRESS_WIDTH, highest buffer address (sampled on init).
REQ-009 SHALL have port lock, input, 1, high while the read side convolves; freezes the head.
REQ-010 SHALL have port s_valid, input, 1, incoming sample valid.
REQ-011 SHALL have port s_data, input, DATA_WIDTH, incoming sample.
REQ-012 SHALL have port s_ready, output, 1, sample accepted when s_valid and s_ready both high.
REQ-013 SHALL have port ram_we, output, 1, registered RAM write enable.
REQ-014 SHALL have port ram_addr, output, DATA_ADDRESS_WIDTH, registered RAM write address.
REQ-015 SHALL have port ram_wdata, output, DATA_WIDTH, registered RAM write data.
REQ-016 SHALL have port head_offset, output, DATA_OFFSET_WIDTH, offset of newest sample from uptr; feeds the read-side driver.
REQ-017 SHALL have port new_sample, output, 1, one-cycle pulse coincident with each sample write.
REQ-018 SHALL have port busy, output, 1, high during zero-fill.

Function
REQ-019 SHALL implement states IDLE, FILL, RUN; clr -> IDLE; init (any state) -> FILL; FILL -> RUN after writing lptr; RUN holds until init or clr.
REQ-020 On init SHALL latch uptr_reg/lptr_reg, set head_offset=0, set fill pointer to data_uptr.
REQ-021 In FILL SHALL write one zero per cycle: ram_we=1, ram_wdata=0, ram_addr ascending uptr_reg..lptr_reg, exactly (lptr_reg-uptr_reg+1) writes; busy=1 for those cycles.
REQ-022 s_ready SHALL be combinational: 1 only when state=RUN and lock=0; 0 in IDLE, FILL, and on the init cycle.
REQ-023 On accept SHALL compute next = (uptr_reg+head_offset == lptr_reg) ? 0 : head_offset+1, then next edge: head_offset<=next, ram_addr<=uptr_reg+next (zero-extended, mod 2^DATA_ADDRESS_WIDTH), ram_wdata<=s_data, ram_we<=1, new_sample<=1 (one cycle latency).
REQ-024 Without accept in RUN, ram_we and new_sample SHALL be 0 and head_offset SHALL hold.
REQ-025 lock rising while s_valid high SHALL block acceptance that cycle; no partial write.
REQ-026 Simultaneous init and accept-candidate: init wins, sample not accepted (s_ready=0).
REQ-027 Simultaneous clr and init: clr wins.
REQ-028 uptr=lptr (length 1): FILL one write; every sample written at uptr, head_offset stays 0.
REQ-029 lptr<uptr or length>2^DATA_OFFSET_WIDTH SHALL be illegal; under DEBUG SHALL $display an error and $finish(2).

Reset
REQ-030 On clr: state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, head_offset=0, new_sample=0, busy=0, uptr_reg=lptr_reg=0, s_ready=0, from the next edge.
REQ-031 clr mid-FILL or mid-write SHALL abort with no further ram_we.

Verification
REQ-032 clr 2 cycles -> all outputs 0, s_ready=0 with s_valid=1.
REQ-033 init, uptr=0x100, lptr=0x103 -> busy 4 cycles, ram_we addr 0x100,0x101,0x102,0x103 data 0; then s_ready=1, head_offset=0.
REQ-034 After REQ-033, stream 0x0A..0x0E back-to-back -> writes at 0x101,0x102,0x103,0x100,0x101; head_offset 1,2,3,0,1; 5 new_sample pulses.
REQ-035 lock=1 with s_valid=1 for 3 cycles -> s_ready=0, no writes, head_offset held; lock=0 -> write on next edge.
REQ-036 init mid-RUN (head_offset=2) -> head_offset=0, full 4-write zero-fill, pending sample not written.
REQ-037 clr during 2nd FILL cycle -> ram_we=0 next edge, state IDLE, busy=0.
